set_assoc_cache: RTL and testbench

Parametrised N-way set-associative, write-hit-update cache with an integrated block-fill controller. It is the next-generation replacement for the fixed 2-way, 8-word-block instruction/data cache. It sits between the pipeline fetch or memory stage and the shared multi-cycle memory. Relative to the 2-way version it adds:
- configurable ways, sets and block size;
- true-LRU replacement across all ways;
- an explicit request/grant arbitration handshake;
- optional hit/miss statistics.

---
 rtl/cache_pkg.sv | 43 ++++
 rtl/set_assoc_cache_if.sv | 39 +++
 rtl/cache_lru_tracker.sv | 68 ++++++
 rtl/set_assoc_cache.sv | 176 +++++++++++++++++
 tb/tb_set_assoc_cache.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the set-associative cache.
// Widths depend on module parameters, so the helpers are constant functions.
package cache_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam int DEF_WAYS        = 2;
  localparam int DEF_SETS        = 64;
  localparam int DEF_BLOCK_WORDS = 8;

  function automatic int off_w(input int block_words);
    return $clog2(block_words) + 1;
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int block_words);
    return ADDR_W - off_w(block_words) - idx_w(sets);
  endfunction

  localparam int OFF_W = off_w(DEF_BLOCK_WORDS);
  localparam int IDX_W = idx_w(DEF_SETS);
  localparam int TAG_W = tag_w(DEF_SETS, DEF_BLOCK_WORDS);

  // Widest tag any legal configuration produces (2 sets, 2-word blocks).
  localparam int MAX_TAG_W = ADDR_W - 2 - 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_GRANT = 2'd1,
    FILL       = 2'd2,
    COMMIT     = 2'd3
  } cache_state_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
  } tag_meta_t;

endpackage

// File: rtl/set_assoc_cache_if.sv
// Pipeline request and memory fill signals between the cache (slave) and its
// environment (master). dbg_state mirrors the fill FSM for observation.
interface set_assoc_cache_if;
  import cache_pkg::*;

  // Request handshake: a request is taken only in a cycle where req_valid=1 and
  // cache_stall=0; while cache_stall=1 the requester holds req_* unchanged.
  logic         req_valid;
  logic         req_write;
  logic [15:0]  req_addr;
  logic [15:0]  req_wdata;
  logic [15:0]  rd_data;
  logic         hit;
  logic         miss_detected;
  logic         cache_stall;

  logic         mem_req;
  logic         mem_grant;
  logic [15:0]  mem_addr;
  logic [15:0]  mem_data_in;
  logic         mem_data_valid;

  cache_state_t dbg_state;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  mem_grant, mem_data_in, mem_data_valid,
    output rd_data, hit, miss_detected, cache_stall,
    output mem_req, mem_addr, dbg_state
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output mem_grant, mem_data_in, mem_data_valid,
    input  rd_data, hit, miss_detected, cache_stall,
    input  mem_req, mem_addr, dbg_state
  );

endinterface

// File: rtl/cache_lru_tracker.sv
// Per-set true-LRU age ranks (0 = MRU) with victim selection: the first
// invalid way wins, otherwise the way holding the oldest rank.
module cache_lru_tracker #(
  parameter int WAYS  = 2,
  parameter int SETS  = 64,
  parameter int WAY_W = 1,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] lookup_set,
  input  logic [WAYS-1:0]  lookup_valid,
  output logic [WAY_W-1:0] victim_way,
  input  logic             touch_en,
  input  logic [IDX_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way
);

  if (WAYS > 1) begin : g_lru
    localparam int RANK_W = $clog2(WAYS);

    logic [RANK_W-1:0] rank [SETS][WAYS];
    logic              found;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) begin
            rank[s][w] <= RANK_W'(w);
          end
        end
      end else if (touch_en) begin
        // Only ways younger than the touched one age; older ranks stay put.
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == touch_way) begin
            rank[touch_set][w] <= '0;
          end else if (rank[touch_set][w] < rank[touch_set][touch_way]) begin
            rank[touch_set][w] <= rank[touch_set][w] + 1'b1;
          end
        end
      end
    end

    always_comb begin
      victim_way = '0;
      found      = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        if (!found && !lookup_valid[w]) begin
          victim_way = WAY_W'(w);
          found      = 1'b1;
        end
      end
      if (!found) begin
        for (int w = 0; w < WAYS; w++) begin
          if (rank[lookup_set][w] == RANK_W'(WAYS - 1)) begin
            victim_way = WAY_W'(w);
          end
        end
      end
    end
  end else begin : g_single
    logic unused_lru;
    assign unused_lru = ^{clk, rst_n, lookup_set, lookup_valid,
                          touch_en, touch_set, touch_way};
    assign victim_way = '0;
  end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-hit-update cache with block-fill controller.
// Defining CACHE_STATS_EN adds saturating hit/miss counters as extra ports.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int WAYS        = DEF_WAYS,
  parameter int SETS        = DEF_SETS,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  set_assoc_cache_if.slave  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int C_OFF  = off_w(BLOCK_WORDS);
  localparam int C_IDX  = idx_w(SETS);
  localparam int C_TAG  = tag_w(SETS, BLOCK_WORDS);
  localparam int WSEL   = C_OFF - 1;
  localparam int CNT_W  = WSEL + 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WSEL-1:0]  req_word;
  logic [C_IDX-1:0] req_idx;
  logic [C_TAG-1:0] req_tag;
  logic             unused_addr_lsb;

  assign req_word        = bus.req_addr[C_OFF-1:1];
  assign req_idx         = bus.req_addr[C_OFF+C_IDX-1:C_OFF];
  assign req_tag         = bus.req_addr[ADDR_W-1:C_OFF+C_IDX];
  assign unused_addr_lsb = bus.req_addr[0];

  tag_meta_t         meta     [WAYS][SETS];
  logic [DATA_W-1:0] data_mem [WAYS][SETS][BLOCK_WORDS];

  cache_state_t     state, state_n;
  logic [WAY_W-1:0] victim_way, victim;
  logic [C_IDX-1:0] fill_idx;
  logic [C_TAG-1:0] fill_tag;
  logic [CNT_W-1:0] issue_cnt, rcv_cnt;

  logic [WAYS-1:0]   valid_vec;
  logic              lookup_hit;
  logic [WAY_W-1:0]  hit_way;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    valid_vec  = '0;
    lookup_hit = 1'b0;
    hit_way    = '0;
    rd_word    = '0;
    for (int w = 0; w < WAYS; w++) begin
      valid_vec[w] = meta[w][req_idx].valid;
      if (meta[w][req_idx].valid && meta[w][req_idx].tag == MAX_TAG_W'(req_tag)) begin
        lookup_hit = 1'b1;
        hit_way    = WAY_W'(w);
        rd_word    = data_mem[w][req_idx][req_word];
      end
    end
  end

  logic is_idle, read_miss, wr_hit, any_hit, issuing, fill_last;

  assign is_idle   = (state == IDLE);
  assign any_hit   = is_idle && bus.req_valid && lookup_hit;
  assign read_miss = is_idle && bus.req_valid && !bus.req_write && !lookup_hit;
  assign wr_hit    = any_hit && bus.req_write;
  assign issuing   = (state == FILL) && (issue_cnt < CNT_W'(BLOCK_WORDS));
  assign fill_last = bus.mem_data_valid && (rcv_cnt == CNT_W'(BLOCK_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n           = state;
    bus.hit           = lookup_hit;
    bus.rd_data       = lookup_hit ? rd_word : '0;
    bus.miss_detected = is_idle && bus.req_valid && !lookup_hit;
    bus.cache_stall   = !is_idle || read_miss;
    bus.mem_req       = (state == WAIT_GRANT) || (state == FILL);
    bus.mem_addr      = issuing ? {fill_tag, fill_idx, issue_cnt[WSEL-1:0], 1'b0} : '0;
    bus.dbg_state     = state;
    case (state)
      IDLE:       if (read_miss)         state_n = WAIT_GRANT;
      WAIT_GRANT: if (bus.mem_grant)     state_n = FILL;
      FILL:       if (fill_last)         state_n = COMMIT;
      COMMIT:                            state_n = IDLE;
      default:                           state_n = IDLE;
    endcase
  end

  // The victim is invalidated as soon as the miss is taken so a partial
  // block can never hit, whether the fill completes or is aborted by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      victim_way <= '0;
      fill_idx   <= '0;
      fill_tag   <= '0;
      issue_cnt  <= '0;
      rcv_cnt    <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          meta[w][s] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: if (read_miss) begin
          victim_way                <= victim;
          fill_idx                  <= req_idx;
          fill_tag                  <= req_tag;
          issue_cnt                 <= '0;
          rcv_cnt                   <= '0;
          meta[victim][req_idx].valid <= 1'b0;
        end
        FILL: begin
          if (issuing)            issue_cnt <= issue_cnt + 1'b1;
          if (bus.mem_data_valid) rcv_cnt   <= rcv_cnt + 1'b1;
        end
        COMMIT: meta[victim_way][fill_idx] <= '{valid: 1'b1, tag: MAX_TAG_W'(fill_tag)};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_hit) begin
      data_mem[hit_way][req_idx][req_word] <= bus.req_wdata;
    end else if (state == FILL && bus.mem_data_valid) begin
      data_mem[victim_way][fill_idx][rcv_cnt[WSEL-1:0]] <= bus.mem_data_in;
    end
  end

  logic             touch_en;
  logic [C_IDX-1:0] touch_set;
  logic [WAY_W-1:0] touch_way;

  assign touch_en  = any_hit || (state == COMMIT);
  assign touch_set = (state == COMMIT) ? fill_idx   : req_idx;
  assign touch_way = (state == COMMIT) ? victim_way : hit_way;

  cache_lru_tracker #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .WAY_W (WAY_W),
    .IDX_W (C_IDX)
  ) u_lru (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_set   (req_idx),
    .lookup_valid (valid_vec),
    .victim_way   (victim),
    .touch_en     (touch_en),
    .touch_set    (touch_set),
    .touch_way    (touch_way)
  );

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (any_hit && stat_hits != '1)     stat_hits   <= stat_hits + 1'b1;
      if (read_miss && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache (default parameters): cold fill, write
// hit, set-conflict eviction, write miss, reset abort mid-fill, optional stats.
module tb_set_assoc_cache;
  import cache_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  set_assoc_cache_if bus();

`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  set_assoc_cache dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_addr       = '0;
    bus.req_wdata      = '0;
    bus.mem_grant      = 1'b0;
    bus.mem_data_in    = '0;
    bus.mem_data_valid = 1'b0;
    rst_n              = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Look at the tag match without issuing a request (no LRU touch).
  task automatic peek(input string tag, input logic [15:0] addr,
                      input logic exp_hit, input logic [15:0] exp_data);
    bus.req_valid = 1'b0;
    bus.req_addr  = addr;
    @(negedge clk);
    check({tag, "_hit"},  bus.hit,     exp_hit);
    check({tag, "_data"}, bus.rd_data, exp_data);
    step();
  endtask

  task automatic read_hit(input string tag, input logic [15:0] addr, input logic [15:0] exp_data);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = addr;
    @(negedge clk);
    check({tag, "_hit"},   bus.hit,         1'b1);
    check({tag, "_data"},  bus.rd_data,     exp_data);
    check({tag, "_stall"}, bus.cache_stall, 1'b0);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic write_req(input string tag, input logic [15:0] addr, input logic [15:0] data,
                           input logic exp_hit);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    @(negedge clk);
    check({tag, "_hit"},   bus.hit,           exp_hit);
    check({tag, "_miss"},  bus.miss_detected, !exp_hit);
    check({tag, "_stall"}, bus.cache_stall,   1'b0);
    check({tag, "_mreq"},  bus.mem_req,       1'b0);
    step();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    @(negedge clk);
    check({tag, "_mreq_next"}, bus.mem_req, 1'b0);
    step();
  endtask

  // Read miss then block fill: grant in the first WAIT_GRANT cycle, data for
  // issue k returned 3 cycles later as dbase+k. abort_after >= 0 pulls rst_n
  // low once that many words have been delivered.
  task automatic read_fill(input string tag, input logic [15:0] addr,
                           input logic [15:0] dbase, input int abort_after);
    logic [15:0] base;
    logic [15:0] exp_word;
    base     = addr & 16'hFFF0;
    exp_word = dbase + {13'd0, addr[3:1]};
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = addr;
    @(negedge clk);
    check({tag, "_miss_stall"}, bus.cache_stall,   1'b1);
    check({tag, "_miss_det"},   bus.miss_detected, 1'b1);
    check({tag, "_miss_hit"},   bus.hit,           1'b0);
    check({tag, "_mreq_n"},     bus.mem_req,       1'b0);
    step();
    // stray data before FILL must be ignored
    bus.mem_data_valid = 1'b1;
    bus.mem_data_in    = 16'hDEAD;
    @(negedge clk);
    check({tag, "_mreq_wait"}, bus.mem_req, 1'b1);
    check({tag, "_state_wait"}, 32'(bus.dbg_state), 32'(WAIT_GRANT));
    bus.mem_grant = 1'b1;
    step();
    bus.mem_grant      = 1'b0;
    bus.mem_data_valid = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k >= 3 && k <= 10) begin
        bus.mem_data_valid = 1'b1;
        bus.mem_data_in    = dbase + 16'(k - 3);
      end else begin
        bus.mem_data_valid = 1'b0;
      end
      if (abort_after >= 0 && k == 3 + abort_after) begin
        bus.mem_data_valid = 1'b0;
        bus.req_valid      = 1'b0;
        rst_n              = 1'b0;
        #1;
        check({tag, "_abort_mreq"},  bus.mem_req,     1'b0);
        check({tag, "_abort_maddr"}, bus.mem_addr,    16'h0000);
        check({tag, "_abort_stall"}, bus.cache_stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        return;
      end
      @(negedge clk);
      if (k < 8)  check($sformatf("%s_maddr%0d", tag, k), bus.mem_addr, base + 16'(2 * k));
      if (k <= 10) check($sformatf("%s_mreq%0d", tag, k), bus.mem_req, 1'b1);
      if (k == 11) begin
        check({tag, "_commit_mreq"},  bus.mem_req,     1'b0);
        check({tag, "_commit_stall"}, bus.cache_stall, 1'b1);
      end
      if (k == 12) begin
        check({tag, "_retry_hit"},   bus.hit,         1'b1);
        check({tag, "_retry_data"},  bus.rd_data,     exp_word);
        check({tag, "_retry_stall"}, bus.cache_stall, 1'b0);
      end
      step();
    end
    bus.req_valid      = 1'b0;
    bus.mem_data_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // reset state, sampled while rst_n is still low
    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_addr       = 16'h1234;
    bus.req_wdata      = '0;
    bus.mem_grant      = 1'b0;
    bus.mem_data_in    = '0;
    bus.mem_data_valid = 1'b0;
    rst_n              = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req",  bus.mem_req,       1'b0);
    check("rst_mem_addr", bus.mem_addr,      16'h0000);
    check("rst_stall",    bus.cache_stall,   1'b0);
    check("rst_rd_data",  bus.rd_data,       16'h0000);
    check("rst_hit",      bus.hit,           1'b0);
    check("rst_miss",     bus.miss_detected, 1'b0);
    check("rst_state",    32'(bus.dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    step();

    // cold fill and retry hit
    read_fill("cold", 16'h1234, 16'hA000, -1);

    // write hit then read back
    write_req("wr_hit", 16'h1236, 16'hBEEF, 1'b1);
    read_hit("rd_1236", 16'h1236, 16'hBEEF);
    read_hit("rd_1234", 16'h1234, 16'hA002);

    // set-conflict eviction in set 0x23
    read_fill("fill_5634", 16'h5634, 16'hB000, -1);
    read_hit("rd_1234_b", 16'h1234, 16'hA002);
    read_fill("fill_9a34", 16'h9A34, 16'hC000, -1);
    peek("pk_1234", 16'h1234, 1'b1, 16'hA002);
    peek("pk_1236", 16'h1236, 1'b1, 16'hBEEF);
    peek("pk_5634", 16'h5634, 1'b0, 16'h0000);
    peek("pk_9a34", 16'h9A34, 1'b1, 16'hC002);

    // write miss: no allocation, no stall
    write_req("wr_miss", 16'h4000, 16'h1111, 1'b0);
    peek("pk_4000", 16'h4000, 1'b0, 16'h0000);
    read_fill("fill_4000", 16'h4000, 16'hD000, -1);

    // reset during fill after 4 words clears everything
    read_fill("abort", 16'hF234, 16'hF000, 4);
    peek("pk_abort_1234", 16'h1234, 1'b0, 16'h0000);
    peek("pk_abort_9a34", 16'h9A34, 1'b0, 16'h0000);
    peek("pk_abort_4000", 16'h4000, 1'b0, 16'h0000);
    peek("pk_abort_f234", 16'hF234, 1'b0, 16'h0000);
    read_fill("refill", 16'h1234, 16'hE000, -1);

`ifdef CACHE_STATS_EN
    do_reset();
    check("stat_rst_hits",   stat_hits,   32'd0);
    check("stat_rst_misses", stat_misses, 32'd0);
    read_fill("stat_fill", 16'h1234, 16'hA000, -1);
    for (int i = 0; i < 4; i++) read_hit("stat_rd", 16'h1234, 16'hA002);
    @(negedge clk);
    check("stat_hits",   stat_hits,   32'd5);
    check("stat_misses", stat_misses, 32'd1);
`else
    do_reset();
    peek("pk_after_rst", 16'h1234, 1'b0, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
